// File: rtl/jpeg_byte_packer.sv
// jpeg_byte_packer: feeds the jpeg_core inport from a byte stream.
// Bytes are packed little-endian into 32-bit words. Each word carries byte
// strobes and a frame-last flag, and goes out through a 2-entry FIFO.
// Optional feature macro: JPEG_EOI_DETECT_EN. When it is defined, an FF D9
// marker pair also ends the frame, even if byte_last_i is low.
module jpeg_byte_packer #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 byte_valid_i,
  input  logic [7:0]           byte_data_i,
  input  logic                 byte_last_i,
  output logic                 byte_ready_o,
  output logic                 outport_valid_o,
  output logic [31:0]          outport_data_o,
  output logic [3:0]           outport_strb_o,
  output logic                 outport_last_o,
  input  logic                 outport_accept_i,
  output logic [CNT_WIDTH-1:0] word_count_o,
  output logic                 idle_o
);

  logic [23:0]          asm_q, asm_d;
  logic [1:0]           idx_q, idx_d;
  logic [31:0]          mem_data_q [2];
  logic [3:0]           mem_strb_q [2];
  logic                 mem_last_q [2];
  logic                 wr_ptr_q, rd_ptr_q;
  logic [1:0]           count_q, count_d;
  logic                 ready_q;
  logic [CNT_WIDTH-1:0] word_count_q;
  logic                 byte_xfer_s, last_eff_s, complete_s, push_s, pop_s;
  logic [31:0]          word_s;
  logic [3:0]           strb_s;
`ifdef JPEG_EOI_DETECT_EN
  logic                 prev_ff_q;
`endif

  // Completed word: the assembled lanes below idx, then the current byte, then zeros.
  function automatic logic [31:0] build_word(input logic [23:0] lanes,
                                             input logic [1:0] idx,
                                             input logic [7:0] b);
    case (idx)
      2'd0:    build_word = {24'h000000, b};
      2'd1:    build_word = {16'h0000, b, lanes[7:0]};
      2'd2:    build_word = {8'h00, b, lanes[15:0]};
      2'd3:    build_word = {b, lanes[23:0]};
      default: build_word = {24'h000000, b};
    endcase
  endfunction

  // Strobes: the low idx+1 lanes are valid.
  function automatic logic [3:0] build_strb(input logic [1:0] idx);
    case (idx)
      2'd0:    build_strb = 4'h1;
      2'd1:    build_strb = 4'h3;
      2'd2:    build_strb = 4'h7;
      2'd3:    build_strb = 4'hF;
      default: build_strb = 4'h1;
    endcase
  endfunction

  // Handshakes, word completion, assembly next-state and FIFO occupancy.
  always_comb begin
    byte_xfer_s = byte_valid_i & ready_q;
`ifdef JPEG_EOI_DETECT_EN
    last_eff_s  = byte_last_i | (prev_ff_q & (byte_data_i == 8'hD9));
`else
    last_eff_s  = byte_last_i;
`endif
    complete_s  = byte_xfer_s & ((idx_q == 2'd3) | last_eff_s);
    push_s      = complete_s;
    pop_s       = (count_q != 2'd0) & outport_accept_i;
    word_s      = build_word(asm_q, idx_q, byte_data_i);
    strb_s      = build_strb(idx_q);
    asm_d       = asm_q;
    idx_d       = idx_q;
    if (complete_s) begin
      idx_d = 2'd0;
    end else if (byte_xfer_s) begin
      idx_d = idx_q + 2'd1;
      case (idx_q)
        2'd0:    asm_d[7:0]   = byte_data_i;
        2'd1:    asm_d[15:8]  = byte_data_i;
        2'd2:    asm_d[23:16] = byte_data_i;
        default: asm_d        = asm_q;
      endcase
    end else begin
      idx_d = idx_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Assembly, occupancy, registered ready and the accepted-word counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      asm_q        <= 24'h000000;
      idx_q        <= 2'd0;
      count_q      <= 2'd0;
      ready_q      <= 1'b0;
      word_count_q <= '0;
    end else begin
      asm_q   <= asm_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      // Ready is deasserted while the FIFO is full, so a completing byte always finds a free slot.
      ready_q <= (count_d < 2'd2);
      if (pop_s) begin
        word_count_q <= word_count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        word_count_q <= word_count_q;
      end
    end
  end

  // Two-entry in-order output FIFO; storage is cleared so outputs read zero after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_data_q[0] <= 32'h00000000;
      mem_data_q[1] <= 32'h00000000;
      mem_strb_q[0] <= 4'h0;
      mem_strb_q[1] <= 4'h0;
      mem_last_q[0] <= 1'b0;
      mem_last_q[1] <= 1'b0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
    end else begin
      if (push_s) begin
        mem_data_q[wr_ptr_q] <= word_s;
        mem_strb_q[wr_ptr_q] <= strb_s;
        mem_last_q[wr_ptr_q] <= last_eff_s;
        wr_ptr_q             <= ~wr_ptr_q;
      end else begin
        wr_ptr_q <= wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_q <= ~rd_ptr_q;
      end else begin
        rd_ptr_q <= rd_ptr_q;
      end
    end
  end

`ifdef JPEG_EOI_DETECT_EN
  // Remember whether the previous accepted byte of this frame was 0xFF.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_ff_q <= 1'b0;
    end else if (byte_xfer_s) begin
      prev_ff_q <= ~last_eff_s & (byte_data_i == 8'hFF);
    end else begin
      prev_ff_q <= prev_ff_q;
    end
  end
`endif

  assign byte_ready_o    = ready_q;
  assign outport_valid_o = (count_q != 2'd0);
  assign outport_data_o  = mem_data_q[rd_ptr_q];
  assign outport_strb_o  = mem_strb_q[rd_ptr_q];
  assign outport_last_o  = mem_last_q[rd_ptr_q];
  assign word_count_o    = word_count_q;
  assign idle_o          = (idx_q == 2'd0) & (count_q == 2'd0);

endmodule

// File: tb/tb_jpeg_byte_packer.sv
// Directed self-checking bench for jpeg_byte_packer.
// Inputs are driven 1 time unit after posedge; transfers are observed at negedge.
module tb_jpeg_byte_packer;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        byte_valid_i = 1'b0;
  logic [7:0]  byte_data_i = 8'h00;
  logic        byte_last_i = 1'b0;
  logic        byte_ready_o;
  logic        outport_valid_o;
  logic [31:0] outport_data_o;
  logic [3:0]  outport_strb_o;
  logic        outport_last_o;
  logic        outport_accept_i = 1'b0;
  logic [15:0] word_count_o;
  logic        idle_o;

  int total = 0;
  int bad = 0;
  logic [36:0] got_q [$];

  jpeg_byte_packer #(.CNT_WIDTH(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .byte_valid_i(byte_valid_i), .byte_data_i(byte_data_i), .byte_last_i(byte_last_i),
    .byte_ready_o(byte_ready_o),
    .outport_valid_o(outport_valid_o), .outport_data_o(outport_data_o),
    .outport_strb_o(outport_strb_o), .outport_last_o(outport_last_o),
    .outport_accept_i(outport_accept_i),
    .word_count_o(word_count_o), .idle_o(idle_o)
  );

  always #5 clk_i = ~clk_i;

  // Record every word transfer that will happen at the next posedge.
  always @(negedge clk_i) begin
    if (!rst_i && outport_valid_o && outport_accept_i)
      got_q.push_back({outport_last_o, outport_strb_o, outport_data_o});
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic [31:0] d, input logic [3:0] s, input logic l);
    check_val({tag, "_valid"}, {31'd0, outport_valid_o}, 32'd1);
    check_val({tag, "_data"}, outport_data_o, d);
    check_val({tag, "_strb"}, {28'd0, outport_strb_o}, {28'd0, s});
    check_val({tag, "_last"}, {31'd0, outport_last_o}, {31'd0, l});
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int  n;
    bit  ok;
    byte_valid_i = 1'b1;
    byte_data_i  = d;
    byte_last_i  = l;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 200) begin
      @(negedge clk_i);
      ok = byte_ready_o;
      @(posedge clk_i);
      #1;
      n++;
    end
    byte_valid_i = 1'b0;
    byte_last_i  = 1'b0;
    if (!ok) check_val("byte_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
  endtask

  logic [36:0] w;

  initial begin
    // Reset values while rst_i is held high.
    repeat (2) @(posedge clk_i);
    #1;
    check_val("rst_valid", {31'd0, outport_valid_o}, 32'd0);
    check_val("rst_data", outport_data_o, 32'd0);
    check_val("rst_strb", {28'd0, outport_strb_o}, 32'd0);
    check_val("rst_last", {31'd0, outport_last_o}, 32'd0);
    check_val("rst_ready", {31'd0, byte_ready_o}, 32'd0);
    check_val("rst_wc", {16'd0, word_count_o}, 32'd0);
    check_val("rst_idle", {31'd0, idle_o}, 32'd1);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    check_val("post_rst_ready", {31'd0, byte_ready_o}, 32'd1);

    // Full word; valid must be visible right after the 4th byte's edge.
    outport_accept_i = 1'b1;
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    check_head("full", 32'h44332211, 4'hF, 1'b0);
    @(posedge clk_i);
    #1;
    check_val("full_wc", {16'd0, word_count_o}, 32'd1);

    // Partial frames flushed by last; the second push coincides with a pop.
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b1);
    check_head("p2", 32'h0000BBAA, 4'h3, 1'b1);
    send_byte(8'hCC, 1'b1);
    check_head("p1", 32'h000000CC, 4'h1, 1'b1);
    send_byte(8'h10, 1'b0);
    send_byte(8'h20, 1'b0);
    send_byte(8'h30, 1'b1);
    check_head("p3", 32'h00302010, 4'h7, 1'b1);
    repeat (2) @(posedge clk_i);
    #1;
    check_val("p_wc", {16'd0, word_count_o}, 32'd4);
    check_val("p_idle", {31'd0, idle_o}, 32'd1);

    // Stall with accept low; FIFO fills after 8 bytes and the head must hold.
    outport_accept_i = 1'b0;
    for (int i = 1; i <= 8; i++) send_byte(i[7:0], 1'b0);
    check_val("stall_ready", {31'd0, byte_ready_o}, 32'd0);
    check_head("stall_h0", 32'h04030201, 4'hF, 1'b0);
    repeat (3) @(posedge clk_i);
    #1;
    check_head("stall_h3", 32'h04030201, 4'hF, 1'b0);
    check_val("stall_ready3", {31'd0, byte_ready_o}, 32'd0);
    got_q.delete();
    outport_accept_i = 1'b1;
    for (int i = 9; i <= 12; i++) send_byte(i[7:0], 1'b0);
    repeat (4) @(posedge clk_i);
    #1;
    check_val("stall_nwords", got_q.size(), 32'd3);
    if (got_q.size() >= 3) begin
      w = got_q[0]; check_val("stall_w0", w[31:0], 32'h04030201);
      w = got_q[1]; check_val("stall_w1", w[31:0], 32'h08070605);
      w = got_q[2]; check_val("stall_w2", w[31:0], 32'h0C0B0A09);
      check_val("stall_w2_strb", {28'd0, w[35:32]}, 32'hF);
    end

    // Reset mid-frame with one word pending.
    outport_accept_i = 1'b0;
    for (int i = 0; i < 6; i++) send_byte(8'hE0 + i[7:0], 1'b0);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    check_val("mrst_valid", {31'd0, outport_valid_o}, 32'd0);
    check_val("mrst_data", outport_data_o, 32'd0);
    check_val("mrst_idle", {31'd0, idle_o}, 32'd1);
    check_val("mrst_wc", {16'd0, word_count_o}, 32'd0);
    check_val("mrst_ready", {31'd0, byte_ready_o}, 32'd0);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    outport_accept_i = 1'b1;
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b1);
    check_head("mrst_fresh", 32'h00006655, 4'h3, 1'b1);
    repeat (2) @(posedge clk_i);
    #1;

`ifdef JPEG_EOI_DETECT_EN
    // FF D9 ends the frame without byte_last_i.
    send_byte(8'h00, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'hD9, 1'b0);
    check_head("eoi", 32'h00D9FF00, 4'h7, 1'b1);
    send_byte(8'hFF, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'hD9, 1'b0);
    send_byte(8'h01, 1'b0);
    check_head("no_eoi", 32'h01D900FF, 4'hF, 1'b0);
`else
    // Without detection FF D9 is ordinary data.
    send_byte(8'hFF, 1'b0);
    send_byte(8'hD9, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    check_head("no_eoi", 32'h0201D9FF, 4'hF, 1'b0);
`endif
    repeat (2) @(posedge clk_i);
    #1;

    // Counter wrap using one-byte frames (one word per cycle).
    do_reset();
    outport_accept_i = 1'b1;
    for (int i = 0; i < 65535; i++) send_byte(i[7:0], 1'b1);
    repeat (3) @(posedge clk_i);
    #1;
    check_val("wc_max", {16'd0, word_count_o}, 32'h0000FFFF);
    send_byte(8'h5A, 1'b1);
    send_byte(8'hA5, 1'b1);
    repeat (3) @(posedge clk_i);
    #1;
    check_val("wc_wrap", {16'd0, word_count_o}, 32'd1);
    check_val("wc_idle", {31'd0, idle_o}, 32'd1);
    got_q.delete();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jpeg_byte_packer.md
Name: jpeg_byte_packer

Overview:
- Transmitter for the jpeg_core input stream.
- Accepts a JPEG file as a byte stream with a valid/ready handshake.
- Packs bytes little-endian into 32-bit words with byte strobes and a frame-last flag.
- Drives the core's inport_valid/data/strb/last/accept interface through a 2-entry output FIFO, so byte_ready_o is a registered signal.

Parameters:
CNT_WIDTH, 16, width of the accepted-word counter word_count_o

Ports:
clk_i  in  1  clock, all logic on posedge
rst_i  in  1  synchronous active-high reset
byte_valid_i  in  1  input byte valid
byte_data_i  in  8  input byte
byte_last_i  in  1  final byte of frame (qualified by byte_valid_i)
byte_ready_o  out  1  packer can accept a byte this cycle
outport_valid_o  out  1  word valid toward jpeg_core inport_valid_i
outport_data_o  out  32  packed word, first byte in [7:0]
outport_strb_o  out  4  byte-lane strobes, bit k covers [8k+7:8k]
outport_last_o  out  1  word holds frame's final byte
outport_accept_i  in  1  downstream accepted current word
word_count_o  out  CNT_WIDTH  words accepted downstream since reset, wraps
idle_o  out  1  no partial word assembled and FIFO empty

Behaviour:
- Byte transfer occurs when byte_valid_i & byte_ready_o. Word transfer occurs when outport_valid_o & outport_accept_i.
- Assembly register:
  - Holds lanes 0..2 plus a 2-bit lane index.
  - A byte transfer writes lane[idx].
  - If idx==3 or the byte is last, the word completes that cycle:
    - Completed word = assembled lanes + current byte.
    - strb = low (idx+1) bits set; unused lanes forced to 0x00.
    - last = byte is last.
    - Word is pushed into the FIFO; idx returns to 0.
  - Otherwise idx increments.
- Output FIFO:
  - 2 entries {data, strb, last}, in-order.
  - Push and pop may occur in the same cycle; count is unchanged when both happen.
  - outport_* present the head entry.
  - outport_valid_o = count!=0. Head is held stable while valid and not accepted.
- byte_ready_o:
  - Registered.
  - High next cycle iff the next-state count is < 2, or the next-state count is 2 and a pop occurs... simplified rule: byte_ready_o <= (count_next < 2).
  - Consequence: a completing byte is never accepted without a free slot. Non-completing bytes are also blocked while the FIFO is full (conservative, accepted cost).
- Latency: the byte that completes a word at posedge N gives outport_valid_o high after posedge N (visible in cycle N+1) when the FIFO was empty.
- Throughput: 1 byte/cycle sustained with outport_accept_i held high. Output is 1 word per 4 cycles.
- Frame boundary: a last byte at any lane flushes a partial word. The next byte starts a new word at lane 0. There are no empty frames.
- word_count_o increments by 1 per word transfer and wraps from 2^CNT_WIDTH-1 to 0.
- idle_o = (idx==0) & (count==0), combinational from registers.
- Reset (synchronous, also mid-frame):
  - idx=0, FIFO count=0, assembled lanes=0.
  - outport_valid_o=0, outport_data_o=0, outport_strb_o=0, outport_last_o=0.
  - byte_ready_o=0 during reset, 1 on the first cycle after reset deasserts.
  - word_count_o=0, idle_o=1.
  - Partial words are discarded.
- Inputs are ignored while rst_i is high.

Optional Feature:
JPEG_EOI_DETECT_EN
- Defined:
  - Register prev_ff is set when an accepted byte is 0xFF, and cleared by any other accepted byte, a frame end, or reset.
  - An accepted 0xD9 with prev_ff=1 is treated as a last byte even if byte_last_i=0 (end-of-image marker).
  - byte_last_i still terminates frames independently.
- Undefined: only byte_last_i terminates frames, and prev_ff is absent.

Test Plan:
- Reset, then bytes 0x11,0x22,0x33,0x44 back-to-back, accept high -> one word data=0x44332211, strb=4'hF, last=0, valid one cycle after 4th byte, word_count_o=1.
- Bytes 0xAA,0xBB with last on 0xBB -> data=0x0000BBAA, strb=4'h3, last=1. Next byte 0xCC,last -> data=0x000000CC, strb=4'h1, last=1.
- Accept held low, stream 12 bytes -> two words queued, byte_ready_o drops to 0 after 8th byte. Accept raised -> words emerge in order with data stable while stalled, and all 12 bytes arrive as 3 words.
- Assert rst_i after 2 bytes of a word with 1 word pending -> outputs return to reset values next cycle, idle_o=1, and next bytes start a fresh word at lane 0.
- With JPEG_EOI_DETECT_EN: bytes 0x00,0xFF,0xD9 with byte_last_i=0 -> data=0x00D9FF00, strb=4'h7, last=1. Bytes 0xFF,0x00,0xD9 -> no last. Without the macro -> 0xFF,0xD9 gives no last.
- Run 65537 words with CNT_WIDTH=16 -> word_count_o wraps to 1.
